lwe_encrypt: RTL and testbench



---
 rtl/lwe_pkg.sv | 26 ++
 rtl/lwe_masked_sum.sv | 49 ++++
 rtl/lwe_encrypt.sv | 55 +++++
 tb/tb_lwe_encrypt.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/lwe_pkg.sv
// Shared constants and elaboration-time helpers for the LWE encryption datapath.
package lwe_pkg;

    localparam int PLAINTEXT_MODULUS  = 64;
    localparam int PLAINTEXT_WIDTH    = 6;
    localparam int CIPHERTEXT_MODULUS = 1024;
    localparam int CIPHERTEXT_WIDTH   = 21;
    localparam int DIMENSION          = 1;
    localparam int BIG_N              = 30;

    // Scale factor q/p that lifts the plaintext into the high bits of the b row.
    function automatic int lwe_delta(input int q, input int p);
        return q / p;
    endfunction

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int lwe_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lwe_masked_sum.sv
// Sum of the public-key entries selected by a mask, wrapping at the entry width.
// The operands are padded to a power of two and reduced by a balanced adder tree.
module lwe_masked_sum
    import lwe_pkg::*;
#(
    parameter int BIG_N            = lwe_pkg::BIG_N,
    parameter int CIPHERTEXT_WIDTH = lwe_pkg::CIPHERTEXT_WIDTH
) (
    input  logic [CIPHERTEXT_WIDTH-1:0] entries [BIG_N-1:0],
    input  logic [BIG_N-1:0]            mask,
    output logic [CIPHERTEXT_WIDTH-1:0] sum
);

    localparam int LEVELS = lwe_clog2(BIG_N);
    localparam int LEAVES = 1 << LEVELS;

    logic [CIPHERTEXT_WIDTH-1:0] leaf [LEAVES-1:0];
    logic [CIPHERTEXT_WIDTH-1:0] tree [LEVELS:0][LEAVES-1:0];

    // Unselected entries and the padding leaves contribute zero.
    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < BIG_N) begin : g_entry
            assign leaf[i] = mask[i] ? entries[i] : '0;
        end else begin : g_pad
            assign leaf[i] = '0;
        end
    end

    // Pairwise reduction, one tree level per outer iteration; carries out of
    // the top bit are dropped so every addition wraps modulo 2^CIPHERTEXT_WIDTH.
    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            for (int j = 0; j < LEAVES; j++) begin
                tree[l][j] = '0;
            end
        end
        for (int j = 0; j < LEAVES; j++) begin
            tree[0][j] = leaf[j];
        end
        for (int l = 1; l <= LEVELS; l++) begin
            for (int j = 0; j < (LEAVES >> l); j++) begin
                tree[l][j] = tree[l-1][2*j] + tree[l-1][2*j+1];
            end
        end
    end

    assign sum = tree[LEVELS][0];

endmodule

// File: rtl/lwe_encrypt.sv
// Combinational ciphertext-component generator: masked sum of one public-key
// row, plus the scaled plaintext when the row is the final (b) row.
module lwe_encrypt
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = lwe_pkg::PLAINTEXT_MODULUS,
    parameter int PLAINTEXT_WIDTH    = lwe_pkg::PLAINTEXT_WIDTH,
    parameter int CIPHERTEXT_MODULUS = lwe_pkg::CIPHERTEXT_MODULUS,
    parameter int CIPHERTEXT_WIDTH   = lwe_pkg::CIPHERTEXT_WIDTH,
    parameter int DIMENSION          = lwe_pkg::DIMENSION,
    parameter int BIG_N              = lwe_pkg::BIG_N
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PLAINTEXT_WIDTH-1:0]  plaintext,
    input  logic [CIPHERTEXT_WIDTH-1:0] publickey_row [BIG_N-1:0],
    input  logic [BIG_N-1:0]            noise_select,
    input  logic [DIMENSION:0]          row,
    output logic [CIPHERTEXT_WIDTH-1:0] ciphertext
);

    localparam int ROW_WIDTH = DIMENSION + 1;
    localparam logic [CIPHERTEXT_WIDTH-1:0] DELTA =
        CIPHERTEXT_WIDTH'(lwe_delta(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS));
    localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(DIMENSION);

    logic [CIPHERTEXT_WIDTH-1:0] masked_sum;
    logic [CIPHERTEXT_WIDTH-1:0] scaled_message;

    // The datapath holds no state; clk and rst_n are only present so the block
    // drops into a clocked controller. Folding them through a constant zero
    // keeps them off every output path, so an X on either cannot leak out.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n};

    lwe_masked_sum #(
        .BIG_N            (BIG_N),
        .CIPHERTEXT_WIDTH (CIPHERTEXT_WIDTH)
    ) u_masked_sum (
        .entries (publickey_row),
        .mask    (noise_select),
        .sum     (masked_sum)
    );

    // Only the exact last-row code carries the message; out-of-range codes
    // behave like an "a" row.
    always_comb begin
        scaled_message = '0;
        if (row == LAST_ROW) begin
            scaled_message = CIPHERTEXT_WIDTH'(plaintext) * DELTA;
        end
        ciphertext = masked_sum + scaled_message;
    end

endmodule

// File: tb/tb_lwe_encrypt.sv
// Self-checking bench for lwe_encrypt: expected values are queued as each
// vector is driven and compared once the combinational output has settled.
module tb_lwe_encrypt;

    localparam int PW = 6;
    localparam int CW = 21;
    localparam int N  = 30;

    logic          clk;
    logic          rst_n;
    logic          clk_en;
    logic [PW-1:0] plaintext;
    logic [CW-1:0] publickey_row [N-1:0];
    logic [N-1:0]  noise_select;
    logic [1:0]    row;
    logic [CW-1:0] ciphertext;

    int n_vec;
    int n_miscmp;

    typedef struct {
        string         tag;
        logic [CW-1:0] value;
    } exp_t;

    exp_t exp_q [$];

    int unsigned spec_ent [30] = '{124312, 58876, 59532, 3836, 94956, 161376, 20564,
                                   92888, 126280, 72980, 101908, 656, 127920, 76980,
                                   75340, 105124, 141104, 23352, 3772, 41656, 28700,
                                   123820, 44344, 7052, 148976, 57300, 17448, 118900,
                                   64352, 55432};

    lwe_encrypt dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .plaintext     (plaintext),
        .publickey_row (publickey_row),
        .noise_select  (noise_select),
        .row           (row),
        .ciphertext    (ciphertext)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miscmp = n_miscmp + 1;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Reference: straight serial sum with explicit wrap, independent of tree shape.
    function automatic logic [CW-1:0] model(input logic [PW-1:0] pt,
                                            input logic [N-1:0] m,
                                            input logic [1:0] r);
        logic [CW:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) acc = (acc + {1'b0, publickey_row[i]}) % (1 << CW);
        end
        if (r == 2'd1) acc = (acc + pt * 16) % (1 << CW);
        return acc[CW-1:0];
    endfunction

    task automatic load_spec_entries();
        for (int i = 0; i < N; i++) publickey_row[i] = CW'(spec_ent[i]);
    endtask

    task automatic drive(input string tag, input logic [PW-1:0] pt,
                         input logic [N-1:0] m, input logic [1:0] r,
                         input logic [CW-1:0] exp);
        exp_t e;
        plaintext    = pt;
        noise_select = m;
        row          = r;
        e.tag   = tag;
        e.value = exp;
        exp_q.push_back(e);
        #10;
        if (exp_q.size() == 0) begin
            n_vec = n_vec + 1;
            n_miscmp = n_miscmp + 1;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, ciphertext, e.value);
        end
    endtask

    localparam logic [N-1:0] PLAN_MASK = 30'b100110001101010110000011000010;

    initial begin
        logic [CW-1:0] held;
        logic [N-1:0]  rmask;
        logic [PW-1:0] rpt;
        logic [1:0]    rrow;
        n_vec    = 0;
        n_miscmp = 0;
        clk_en   = 1'b0;
        rst_n    = 1'b0;
        load_spec_entries();

        // Clock held still: output must settle from inputs alone.
        drive("plan_row0", 6'd5, PLAN_MASK, 2'd0, 21'd752224);
        drive("plan_row1", 6'd5, PLAN_MASK, 2'd1, 21'd752304);
        drive("model_row0", 6'd5, PLAN_MASK, 2'd0, model(6'd5, PLAN_MASK, 2'd0));
        drive("mask0_row1", 6'd63, '0, 2'd1, 21'd1008);
        drive("mask0_row0", 6'd63, '0, 2'd0, 21'd0);
        drive("row2_no_msg", 6'd5, PLAN_MASK, 2'd2, 21'd752224);
        drive("row3_no_msg", 6'd5, PLAN_MASK, 2'd3, 21'd752224);

        drive("single_k0",  6'd7, 30'd1 << 0,  2'd0, CW'(spec_ent[0]));
        drive("single_k15", 6'd7, 30'd1 << 15, 2'd0, CW'(spec_ent[15]));
        drive("single_k29", 6'd7, 30'd1 << 29, 2'd0, CW'(spec_ent[29]));

        // Reset pulsed with inputs held; output must not move.
        rst_n = 1'b1;
        drive("rst_hold_pre", 6'd5, PLAN_MASK, 2'd1, 21'd752304);
        held = ciphertext;
        rst_n = 1'b0;
        #3;
        chk("rst_low", ciphertext, 21'd752304);
        rst_n = 1'b1;
        #3;
        chk("rst_release", ciphertext, held);

        // X on the clock must not reach the output.
        clk = 1'bx;
        #2;
        chk("clk_x", ciphertext, 21'd752304);
        clk = 1'b0;

        // Now run a free clock; behaviour must be unaffected.
        clk_en = 1'b1;
        for (int i = 0; i < N; i++) publickey_row[i] = '1;
        drive("all_ones_wrap", 6'd0, '1, 2'd0, 21'd2097122);
        drive("all_ones_row1", 6'd63, '1, 2'd1, CW'(21'd2097122 + 21'd1008));

        load_spec_entries();
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++) publickey_row[i] = CW'($urandom);
            rmask = N'($urandom);
            rpt   = PW'($urandom);
            rrow  = 2'($urandom_range(0, 3));
            drive($sformatf("rand%0d", v), rpt, rmask, rrow, model(rpt, rmask, rrow));
        end

        clk_en = 1'b0;
        if (exp_q.size() != 0) begin
            n_vec = n_vec + 1;
            n_miscmp = n_miscmp + 1;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
